// File: rtl/fetch_ctl_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths,
// halfword queue depths for both build flavours, and the queue entry type.
package fetch_ctl_pkg;

  localparam int RV_DEF = 32;
  localparam logic [RV_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Halfword queue depth with and without prefetch.
  localparam int DEPTH_PREFETCH = 4;
  localparam int DEPTH_BASIC    = 2;

  // One queued parcel: instruction halfword, its PC and the fetch error tag.
  typedef struct packed {
    logic [15:0]       ins;
    logic [RV_DEF-1:0] pc;
    logic              fault;
  } fq_entry_t;

  // Word-aligned base of a byte address.
  function automatic logic [RV_DEF-1:0] word_base(input logic [RV_DEF-1:0] a);
    return {a[RV_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctl_if.sv
// Instruction memory port between the fetch sequencer (master) and the
// instruction memory (slave). mem_err is only meaningful with mem_ack.
interface fetch_ctl_if #(
  parameter int RV = 32
) ();
  logic          mem_req;
  logic [RV-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/fetch_ctl_queue.sv
// fetch_queue: halfword FIFO with 0/1/2 pushes per cycle, a single pop and a
// flush. DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_ctl_pkg::*;
#(
  parameter int DEPTH = DEPTH_PREFETCH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [1:0]                 push_cnt_i,
  input  fq_entry_t                  push0_i,
  input  fq_entry_t                  push1_i,
  input  logic                       pop_i,
  output fq_entry_t                  head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] free_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, wr1_s;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign wr1_s   = wr_q + PW'(1);
  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == CW'(0));
  assign free_o  = CW'(DEPTH) - cnt_q;

  // Pointer and occupancy update; flush wins over any push or pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PW'(pop_i);
      wr_d  = wr_q + PW'(push_cnt_i);
      cnt_d = cnt_q + CW'(push_cnt_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage: first pushed parcel at the write pointer, second one after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i) begin
      if (push_cnt_i != 2'd0) mem_q[wr_q]  <= push0_i;
      if (push_cnt_i == 2'd2) mem_q[wr1_s] <= push1_i;
    end
  end

endmodule

// File: rtl/fetch_ctl.sv
// fetch_ctl: fetches 32-bit words, splits them into 16-bit parcels and issues
// one parcel per cycle to the decoder. Redirects flush the queue and drop a
// pending response. Build option FETCH_PREFETCH_EN: 4-entry queue with
// request-ahead; otherwise a 2-entry queue refilled only when empty.
module fetch_ctl
  import fetch_ctl_pkg::*;
#(
  parameter int            RV       = RV_DEF,
  parameter logic [RV-1:0] RESET_PC = RV'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  input  logic          stall,
  output logic [15:0]   ins,
  output logic          idone,
  output logic [RV-1:0] ins_pc,
  output logic          fetch_fault,
  fetch_ctl_if.master   mem
);
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = DEPTH_PREFETCH;
`else
  localparam int DEPTH = DEPTH_BASIC;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  logic [RV-1:0] fpc_q, fpc_d, addr_q, addr_d, ins_pc_q, ins_pc_d;
  logic          run_q, outst_q, outst_d, drop_q, drop_d;
  logic          idone_q, idone_d, fault_q, fault_d;
  logic [15:0]   ins_q, ins_d;

  logic [RV-1:0] word_pc_s;
  logic [CW-1:0] free_s;
  logic          empty_s, pop_s, room_s, launch_s, req_s, ack_s, take_s;
  logic [1:0]    push_cnt_s;
  fq_entry_t     head_s, par0_s, par1_s, push0_s, push1_s;

  assign word_pc_s = RV'(word_base(RV_DEF'(fpc_q)));
  assign pop_s     = !empty_s && !stall && !redirect;

`ifdef FETCH_PREFETCH_EN
  // Slots freed by this cycle's issue count towards the two needed for a word.
  logic [CW:0] free_eff_s;
  assign free_eff_s = {1'b0, free_s} + (CW+1)'(pop_s);
  assign room_s     = (free_eff_s >= (CW+1)'(2));
`else
  assign room_s     = (free_s == CW'(DEPTH));
`endif

  // run_q keeps the port quiet until the first edge out of reset.
  assign launch_s = run_q && !outst_q && !redirect && room_s;
  assign req_s    = outst_q || launch_s;
  assign ack_s    = req_s && mem.mem_ack;
  assign take_s   = ack_s && !drop_q && !redirect;

  assign mem.mem_req  = req_s;
  assign mem.mem_addr = outst_q ? addr_q : word_pc_s;

  assign ins         = ins_q;
  assign idone       = idone_q;
  assign ins_pc      = ins_pc_q;
  assign fetch_fault = fault_q;

  // Split the returning word; the low parcel is skipped when fpc targets the high half.
  always_comb begin
    par0_s.ins   = mem.mem_rdata[15:0];
    par0_s.pc    = RV_DEF'(word_pc_s);
    par0_s.fault = mem.mem_err;
    par1_s.ins   = mem.mem_rdata[31:16];
    par1_s.pc    = RV_DEF'({fpc_q[RV-1:2], 2'b10});
    par1_s.fault = mem.mem_err;
    push_cnt_s   = 2'd0;
    push0_s      = par0_s;
    push1_s      = par1_s;
    if (take_s) begin
      if (fpc_q[1]) begin
        push_cnt_s = 2'd1;
        push0_s    = par1_s;
      end else begin
        push_cnt_s = 2'd2;
      end
    end else begin
      push_cnt_s = 2'd0;
    end
  end

  // Fetch PC, request hold and drop tracking; redirect overrides everything else.
  always_comb begin
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (redirect) begin
      fpc_d   = {redirect_pc[RV-1:1], 1'b0};
      outst_d = outst_q && !mem.mem_ack;
      drop_d  = outst_q && !mem.mem_ack;
    end else begin
      outst_d = req_s && !mem.mem_ack;
      if (launch_s) addr_d = word_pc_s;
      else          addr_d = addr_q;
      if (ack_s) drop_d = 1'b0;
      else       drop_d = drop_q;
      if (take_s) fpc_d = word_pc_s + RV'(4);
      else        fpc_d = fpc_q;
    end
  end

  // Issue stage: pop the head into the output registers, otherwise hold.
  always_comb begin
    idone_d  = pop_s;
    ins_d    = ins_q;
    ins_pc_d = ins_pc_q;
    fault_d  = fault_q;
    if (pop_s) begin
      ins_d    = head_s.ins;
      ins_pc_d = RV'(head_s.pc);
      fault_d  = head_s.fault;
    end else begin
      fault_d  = fault_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      fpc_q    <= RESET_PC;
      addr_q   <= '0;
      outst_q  <= 1'b0;
      drop_q   <= 1'b0;
      idone_q  <= 1'b0;
      ins_q    <= 16'h0000;
      ins_pc_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      idone_q  <= idone_d;
      ins_q    <= ins_d;
      ins_pc_q <= ins_pc_d;
      fault_q  <= fault_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (redirect),
    .push_cnt_i (push_cnt_s),
    .push0_i    (push0_s),
    .push1_i    (push1_s),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .empty_o    (empty_s),
    .free_o     (free_s)
  );

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl with an address-derived instruction memory and
// a scoreboard of expected parcels filled as the memory acknowledges words.
module tb_fetch_ctl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct packed {
    logic [15:0] ins;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [15:0] ins;
  logic        idone;
  logic [31:0] ins_pc;
  logic        fetch_fault;

  logic        ack_auto = 1'b0;
  logic        ack_man = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_word = 32'h0;

  int          total = 0;
  int          bad = 0;
  int          nfault = 0;
  int          cnt;
  exp_t        exp_q[$];
  logic [31:0] exp_next = RPC;
  logic        drop_pend = 1'b0;

  fetch_ctl_if #(.RV(32)) mif ();

  fetch_ctl #(.RV(32), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .ins         (ins),
    .idone       (idone),
    .ins_pc      (ins_pc),
    .fetch_fault (fetch_fault),
    .mem         (mif)
  );

  always #5 clk = ~clk;

  // Memory content: each halfword is a scrambled copy of its own address.
  function automatic logic [15:0] parcel(input logic [31:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  assign mif.mem_ack   = ack_auto ? mif.mem_req : ack_man;
  assign mif.mem_rdata = {parcel(mif.mem_addr + 32'd2), parcel(mif.mem_addr)};
  assign mif.mem_err   = err_en && (mif.mem_addr == err_word);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare issued parcels, then account for redirects and acks.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] w;
    logic        f;
    if (!reset) begin
      exp_q.delete();
      exp_next  = RPC;
      drop_pend = 1'b0;
    end else begin
      if (idone) begin
        if (fetch_fault) nfault++;
        if (exp_q.size() == 0) begin
          chk("idone_scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("ins_pc", ins_pc, e.pc);
          chk("ins", 32'(ins), 32'(e.ins));
          chk("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_next  = {redirect_pc[31:1], 1'b0};
        drop_pend = mif.mem_req && !mif.mem_ack;
      end else if (mif.mem_req && mif.mem_ack) begin
        if (drop_pend) begin
          drop_pend = 1'b0;
        end else begin
          w = {exp_next[31:2], 2'b00};
          f = err_en && (w == err_word);
          chk("ack_addr", mif.mem_addr, w);
          if (!exp_next[1]) exp_q.push_back('{parcel(w), w, f});
          exp_q.push_back('{parcel(w + 32'd2), w + 32'd2, f});
          exp_next = w + 32'd4;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    ack_auto = 1'b1;
    #12;
    chk("rst_idone", 32'(idone), 32'd0);
    chk("rst_ins", 32'(ins), 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_req", 32'(mif.mem_req), 32'd1);
    chk("first_addr", mif.mem_addr, RPC);

    // Streaming from reset: wait for the first parcel, then count idone
    for (int i = 0; i < 20; i++) begin
      if (idone) break;
      @(posedge clk); #1;
    end
    chk("first_idone_seen", 32'(idone), 32'd1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (idone) cnt++;
      @(posedge clk); #1;
    end
`ifdef FETCH_PREFETCH_EN
    chk("stream_idone_count", 32'(cnt), 32'd9);
`else
    chk("stream_idone_count", 32'(cnt), 32'd6);
`endif

    // Redirect to 0x206 (bit 0 set and ignored)
    redirect = 1'b1;
    redirect_pc = 32'h0000_0207;
    #1;
    chk("redir_cycle_req", 32'(mif.mem_req), 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    #1;
    chk("redir_next_idone", 32'(idone), 32'd0);
    chk("redir_req", 32'(mif.mem_req), 32'd1);
    chk("redir_addr", mif.mem_addr, 32'h0000_0204);
    repeat (8) @(posedge clk);
    #1;

    // Redirect while a request to 0x108 waits for a late ack
    ack_auto = 1'b0;
    ack_man = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0108;
    @(posedge clk); #1;
    redirect = 1'b0;
    #1;
    chk("drop_req", 32'(mif.mem_req), 32'd1);
    chk("drop_addr", mif.mem_addr, 32'h0000_0108);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    @(posedge clk); #1;
    redirect = 1'b0;
    #1;
    chk("drop_hold_req", 32'(mif.mem_req), 32'd1);
    chk("drop_hold_addr", mif.mem_addr, 32'h0000_0108);
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    #1;
    chk("post_drop_req", 32'(mif.mem_req), 32'd1);
    chk("post_drop_addr", mif.mem_addr, 32'h0000_0400);
    chk("post_drop_idone", 32'(idone), 32'd0);
    ack_auto = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Stall long enough to fill the queue
    stall = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_req_off", 32'(mif.mem_req), 32'd0);
    chk("stall_idone", 32'(idone), 32'd0);
    stall = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Errored fetch of word 0x300
    err_en = 1'b1;
    err_word = 32'h0000_0300;
    nfault = 0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    @(posedge clk); #1;
    redirect = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("fault_parcel_count", 32'(nfault), 32'd2);
    err_en = 1'b0;

    // Reset in the middle of an outstanding request
    ack_auto = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mif.mem_req) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("pre_reset_req", 32'(mif.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(mif.mem_req), 32'd0);
    chk("async_rst_idone", 32'(idone), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ack_auto = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", 32'(mif.mem_req), 32'd1);
    chk("restart_addr", mif.mem_addr, RPC);
    repeat (10) @(posedge clk);
    #1;

    // Stop the memory and let the queue drain: every expected parcel must issue
    ack_auto = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
